sz_inner_core: RTL and testbench
================================

Name:
sz_inner_core

Overview:
- First stages of an SZ-style error-bounded lossy compressor. Accepts one 32-bit sample per enabled clock.
- Each sample is predicted from previously reconstructed samples using three curve-fitting predictors. The block selects the best-fit predictor, quantizes the prediction error against a power-of-two error bound, and outputs:
  - a 2-bit fit type,
  - a 16-bit quantization code,
  - the raw sample whenever it is unpredictable.
- Sits between the sample source and the downstream entropy/packing stages.

Parameters:
- EB_LOG2, 4, error bound EB = 2^EB_LOG2 in sample LSB units; quantization bin width is 2*EB.
- QUANT_BITS, 14, quant code width; INTV_RADIUS = 2^(QUANT_BITS-1) = 8192.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- data_in  input  32  sample, interpreted as a 32-bit signed integer (raw bit pattern, no float decode).
- enable  input  1  sample-valid; data_in accepted on any rising edge with enable=1.
- data_out  output  2  fit type: 0 unpredictable, 1 previous-value, 2 linear, 3 quadratic.
- phase2_data_out  output  16  quant code, zero-extended from QUANT_BITS.
- phase2_valid  output  1  one-cycle pulse per accepted sample.
- phase3_data_out  output  32  raw unpredictable sample.
- phase3_valid  output  1  one-cycle pulse per unpredictable sample.

Behaviour:
- State:
  - Reconstructed history r1 (newest), r2, r3, each 32-bit signed.
  - Count cnt, saturating at 3.
  - On reset all of these are 0. All outputs reset to 0.
- Accept cycle (enable=1). Compute combinationally from x=data_in and history, using ≥35-bit signed arithmetic with no overflow:
  - p1 = r1, eligible if cnt≥1.
  - p2 = 2*r1 - r2, eligible if cnt≥2.
  - p3 = 3*r1 - 3*r2 + r3, eligible if cnt≥3.
  - e_k = x - p_k.
  - Select the eligible k with minimum |e_k|. Ties go to the lower k.
  - If no predictor is eligible, the sample is unpredictable.
- Quantization:
  - q = sign(e) * ((|e| + EB) >> (EB_LOG2+1)), i.e. round half away from zero.
  - Predictable iff a predictor was selected and |q| < INTV_RADIUS.
  - If predictable:
    - type = k.
    - code = q + INTV_RADIUS (range 1..16383).
    - recon = p_k + q*2*EB, truncated to 32 bits. Guarantees |x - recon| ≤ EB.
  - If unpredictable: type = 0, code = 0, recon = x.
- History update in the same accept edge: r3 ← r2, r2 ← r1, r1 ← recon, cnt ← min(cnt+1, 3). Throughput is one sample per clock.
- Output pipeline, relative to accept edge N:
  - data_out registered at edge N (visible cycle N+1) and held until the next accepted sample.
  - phase2_data_out and phase2_valid=1 at edge N+1. phase2_data_out is held afterwards; phase2_valid is 0 when no sample is in that slot.
  - phase3_data_out = x and phase3_valid=1 at edge N+2, only if the sample was unpredictable. Otherwise phase3_valid is 0 and phase3_data_out holds.
- enable=0: no history or cnt change; bubbles propagate (valids low); in-flight samples still drain.
- Reset asserted mid-stream:
  - Immediately clears history, cnt, pipeline registers and all outputs.
  - In-flight samples are discarded.
  - The first sample after reset is unpredictable.

Test Plan:
- Reset for 100 ns, then accept 0x3e702c81 (empty history). Required:
  - data_out=0 next cycle.
  - phase2_data_out=0x0000 with phase2_valid one cycle later.
  - phase3_data_out=0x3e702c81 with phase3_valid one cycle after that.
- Then accept 0x3e702625:
  - e1=-1628, q=-51, type 1, code 0x1FCD.
  - recon 0x3e702621; phase3_valid stays 0.
- Then accept 0x3e7022c4:
  - p2=0x3e701FC1, e2=771 beats e1=-861 → data_out=2.
  - q=24, code 0x2018.
- Step jump of +0x00100000 after steady data: |q| ≥ 8192 → type 0, code 0, phase3 outputs the raw sample; the next sample predicts from that raw value.
- Continuous stream of ~350 samples from the 0x3e6x/0x3e70 families with enable held high:
  - one phase2_valid per sample, no gaps;
  - a reference model confirms |x - recon| ≤ 16 for every predictable sample.
- Deassert enable for 3 cycles mid-stream, then re-assert: history is unchanged and valids are low during the gap. Separately, assert rst mid-stream: all outputs go to 0 immediately, and the first post-reset sample is type 0.

Source files
------------

// File: rtl/sz_inner_core.sv
// SZ-style front end: three-way curve-fit prediction, error-bounded quantization
// and a short output pipeline (fit type -> quant code -> raw unpredictable sample).
module sz_inner_core #(
    parameter int EB_LOG2    = 4,
    parameter int QUANT_BITS = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        enable,
    output logic [1:0]  data_out,
    output logic [15:0] phase2_data_out,
    output logic        phase2_valid,
    output logic [31:0] phase3_data_out,
    output logic        phase3_valid
);
    localparam int W  = 36;
    localparam int SH = EB_LOG2 + 1;
    localparam logic [W-1:0] EB_W   = W'(1) << EB_LOG2;
    localparam logic [W-1:0] INTV_W = W'(1) << (QUANT_BITS - 1);

    logic [31:0] r1, r2, r3;
    logic [1:0]  cnt;

    logic signed [W-1:0] x_w, r1_w, r2_w, r3_w, d12;
    logic signed [W-1:0] p1, p2, p3, e1, e2, e3, sel_e;
    logic [W-1:0]        a1, a2, a3, sel_a, qmag, code_w;
    logic [1:0]          sel;
    logic                predictable;
    logic [31:0]         step32, recon_c;
    logic [1:0]          type_c;
    logic [15:0]         code_c;

    always_comb begin
        x_w  = {{(W-32){data_in[31]}}, data_in};
        r1_w = {{(W-32){r1[31]}}, r1};
        r2_w = {{(W-32){r2[31]}}, r2};
        r3_w = {{(W-32){r3[31]}}, r3};
        d12  = r1_w - r2_w;
        p1   = r1_w;
        p2   = (r1_w <<< 1) - r2_w;
        p3   = (d12 <<< 1) + d12 + r3_w;
        e1   = x_w - p1;
        e2   = x_w - p2;
        e3   = x_w - p3;
        a1   = e1[W-1] ? -e1 : e1;
        a2   = e2[W-1] ? -e2 : e2;
        a3   = e3[W-1] ? -e3 : e3;

        // Strict less-than keeps ties on the lower-order predictor.
        sel   = 2'd0;
        sel_e = e1;
        sel_a = a1;
        if (cnt != 2'd0) sel = 2'd1;
        if (cnt >= 2'd2 && a2 < sel_a) begin
            sel   = 2'd2;
            sel_e = e2;
            sel_a = a2;
        end
        if (cnt == 2'd3 && a3 < sel_a) begin
            sel   = 2'd3;
            sel_e = e3;
            sel_a = a3;
        end

        qmag        = (sel_a + EB_W) >> SH;
        predictable = (sel != 2'd0) && (qmag < INTV_W);
        code_w      = sel_e[W-1] ? (INTV_W - qmag) : (INTV_W + qmag);
        step32      = 32'(qmag << SH);

        // recon = p + q*2EB, with p rebuilt as x - e so only the low 32 bits are needed.
        type_c  = 2'd0;
        code_c  = 16'd0;
        recon_c = data_in;
        if (predictable) begin
            type_c  = sel;
            code_c  = 16'(code_w[QUANT_BITS-1:0]);
            recon_c = sel_e[W-1] ? (data_in - sel_e[31:0] - step32)
                                 : (data_in - sel_e[31:0] + step32);
        end
    end

    logic        s1_valid, s1_unpred, s2_valid;
    logic [15:0] s1_code;
    logic [31:0] s1_x, s2_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1              <= '0;
            r2              <= '0;
            r3              <= '0;
            cnt             <= '0;
            data_out        <= '0;
            s1_valid        <= 1'b0;
            s1_unpred       <= 1'b0;
            s1_code         <= '0;
            s1_x            <= '0;
            s2_valid        <= 1'b0;
            s2_x            <= '0;
            phase2_data_out <= '0;
            phase2_valid    <= 1'b0;
            phase3_data_out <= '0;
            phase3_valid    <= 1'b0;
        end else begin
            if (enable) begin
                r3        <= r2;
                r2        <= r1;
                r1        <= recon_c;
                if (cnt != 2'd3) cnt <= cnt + 2'd1;
                data_out  <= type_c;
                s1_code   <= code_c;
                s1_x      <= data_in;
                s1_unpred <= !predictable;
            end
            s1_valid     <= enable;
            phase2_valid <= s1_valid;
            if (s1_valid) begin
                phase2_data_out <= s1_code;
                s2_x            <= s1_x;
            end
            s2_valid     <= s1_valid && s1_unpred;
            phase3_valid <= s2_valid;
            if (s2_valid) phase3_data_out <= s2_x;
        end
    end
endmodule

// File: tb/tb_sz_inner_core.sv
// Scoreboard bench for sz_inner_core: a queue-based reference model predicts each
// sample's fit type, quant code and raw output with their due cycles.
module tb_sz_inner_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic        enable = 1'b0;
    logic [1:0]  data_out;
    logic [15:0] phase2_data_out;
    logic        phase2_valid;
    logic [31:0] phase3_data_out;
    logic        phase3_valid;

    sz_inner_core #(.EB_LOG2(4), .QUANT_BITS(14)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .enable(enable),
        .data_out(data_out), .phase2_data_out(phase2_data_out), .phase2_valid(phase2_valid),
        .phase3_data_out(phase3_data_out), .phase3_valid(phase3_valid)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard queues with due cycles
    logic [1:0]  type_q[$];
    int          type_due[$];
    logic [15:0] code_q[$];
    int          code_due[$];
    logic [31:0] raw_q[$];
    int          raw_due[$];

    // reference model: reconstructed history, newest first
    longint      hist[$];
    logic [1:0]  last_t;
    logic [15:0] last_c;

    task automatic model(input logic [31:0] x, output logic [1:0] t, output logic [15:0] code,
                         output bit unp);
        longint xv, p, e, a, best_a, best_p, best_e, qm, q, recv;
        int k;
        logic [31:0] rec;
        xv = longint'($signed(x));
        k = 0; best_a = 0; best_p = 0; best_e = 0;
        for (int i = 1; i <= 3; i++) begin
            if (hist.size() >= i) begin
                if (i == 1) p = hist[0];
                else if (i == 2) p = 2 * hist[0] - hist[1];
                else p = 3 * hist[0] - 3 * hist[1] + hist[2];
                e = xv - p;
                a = (e < 0) ? -e : e;
                if (k == 0 || a < best_a) begin
                    k = i; best_a = a; best_p = p; best_e = e;
                end
            end
        end
        qm  = (best_a + 16) / 32;
        unp = (k == 0) || (qm >= 8192);
        if (unp) begin
            t = 2'd0; code = 16'd0; rec = x;
        end else begin
            q    = (best_e < 0) ? -qm : qm;
            t    = 2'(k);
            code = 16'(8192 + q);
            recv = best_p + q * 32;
            rec  = recv[31:0];
            chk("model_err_bound", ((xv - recv) <= 16 && (recv - xv) <= 16) ? 1 : 0, 1);
        end
        hist.push_front(longint'($signed(rec)));
        if (hist.size() > 3) void'(hist.pop_back());
    endtask

    // driver tasks
    task automatic send(input logic [31:0] x);
        logic [1:0] t;
        logic [15:0] c;
        bit u;
        @(negedge clk);
        data_in = x;
        enable  = 1'b1;
        model(x, t, c, u);
        type_q.push_back(t);  type_due.push_back(cyc + 1);
        code_q.push_back(c);  code_due.push_back(cyc + 2);
        if (u) begin
            raw_q.push_back(x); raw_due.push_back(cyc + 3);
        end
        last_t = t;
        last_c = c;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_p2_data"}, phase2_data_out, 0);
        chk({tag, "_p2_valid"}, phase2_valid, 0);
        chk({tag, "_p3_data"}, phase3_data_out, 0);
        chk({tag, "_p3_valid"}, phase3_valid, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        enable = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("mid_reset");
        type_q.delete(); type_due.delete();
        code_q.delete(); code_due.delete();
        raw_q.delete();  raw_due.delete();
        hist.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // monitor: pops and compares whenever an output is due
    always @(negedge clk) begin
        if (!rst) begin
            bit ev2, ev3;
            if (type_q.size() > 0 && type_due[0] == cyc) begin
                chk("data_out", data_out, type_q.pop_front());
                void'(type_due.pop_front());
            end
            ev2 = (code_q.size() > 0 && code_due[0] == cyc);
            chk("phase2_valid", phase2_valid, ev2);
            if (ev2) begin
                chk("phase2_data_out", phase2_data_out, code_q.pop_front());
                void'(code_due.pop_front());
            end
            ev3 = (raw_q.size() > 0 && raw_due[0] == cyc);
            chk("phase3_valid", phase3_valid, ev3);
            if (ev3) begin
                chk("phase3_data_out", phase3_data_out, raw_q.pop_front());
                void'(raw_due.pop_front());
            end
        end
    end

    // stimulus
    initial begin
        logic [31:0] x;
        repeat (10) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        send(32'h3e702c81);
        chk("first_type", last_t, 0);
        chk("first_code", last_c, 0);
        send(32'h3e702625);
        chk("second_type", last_t, 1);
        chk("second_code", last_c, 16'h1FCD);
        chk("second_recon", hist[0], 64'h3e702621);
        send(32'h3e7022c4);
        chk("third_type", last_t, 2);
        chk("third_code", last_c, 16'h2018);

        // steady ramp, then a step jump that overflows the quant range
        x = 32'h3e702400;
        for (int i = 0; i < 10; i++) begin
            x = x + 32'd7;
            send(x);
        end
        x = x + 32'h00100000;
        send(x);
        chk("step_type", last_t, 0);
        send(x + 32'd5);
        chk("after_step_type", last_t, 1);
        idle(4);

        // long randomized stream with an enable gap in the middle
        x = 32'h3e702000;
        for (int i = 0; i < 350; i++) begin
            if (i % 60 == 59) x = 32'h3e600000 + $urandom_range(0, 32'hfffff);
            else if (i % 60 == 29) x = 32'h3e700000 + $urandom_range(0, 32'hffff);
            else x = x + $urandom_range(0, 600) - 32'd300;
            if (i == 175) idle(3);
            send(x);
        end

        // reset while samples are in flight
        mid_reset();
        send(32'h3e6f1234);
        chk("post_reset_type", last_t, 0);
        for (int i = 0; i < 8; i++) send(32'h3e6f1234 + 32'($urandom_range(0, 200)));

        idle(6);
        chk("type_q_drained", type_q.size(), 0);
        chk("code_q_drained", code_q.size(), 0);
        chk("raw_q_drained", raw_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
